// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the instruction-queue FIFO and its bus interface.
package sync_fifo_pkg;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 8;
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
);
  logic             read;
  logic             write;
  logic             empty;
  logic             full;
  logic [width-1:0] data_in;
  logic [width-1:0] data_out;

  modport master (
    output read, write, data_in,
    input  empty, full, data_out
  );

  modport slave (
    input  read, write, data_in,
    output empty, full, data_out
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// depth x width register array: one synchronous write port, one registered read port.
module fifo_mem #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 8,
  localparam int unsigned AW   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register is the visible output word, so it alone carries the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags and accept logic around fifo_mem.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH,
  parameter int unsigned depth = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             write,
  output logic             empty,
  output logic             full,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_acc, rd_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(depth));

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign wr_acc = write && (!full || read);
  assign rd_acc = read && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .width (width),
    .depth (depth)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed scoreboard bench for sync_fifo (width=32, depth=8).
module tb_sync_fifo;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst;

  sync_fifo_if #(.width(32)) bus ();

  sync_fifo #(
    .width (32),
    .depth (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (bus.read),
    .write    (bus.write),
    .empty    (bus.empty),
    .full     (bus.full),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb_q [$];
  logic [31:0] exp_dout;
  int          total;
  int          passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".empty"}, {31'd0, bus.empty}, {31'd0, sb_q.size() == 0});
    chk({tag, ".full"},  {31'd0, bus.full},  {31'd0, sb_q.size() == DEPTH});
    chk({tag, ".dout"},  bus.data_out, exp_dout);
  endtask

  // One clock: drive request, predict from the reference queue, check after the edge.
  task automatic step(input string tag, input logic r, input logic w, input logic [31:0] d);
    bit racc, wacc;
    bus.read    = r;
    bus.write   = w;
    bus.data_in = d;
    racc = r && (sb_q.size() != 0);
    wacc = w && ((sb_q.size() < DEPTH) || r);
    @(posedge clk);
    if (racc) exp_dout = sb_q.pop_front();
    if (wacc) sb_q.push_back(d);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    exp_dout = '0;
    rst         = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    step("post_reset_idle", 1'b0, 1'b0, 32'h0);

    for (int i = 1; i <= 8; i++)
      step("fill", 1'b0, 1'b1, 32'(i) * 32'h1111_1111);
    chk("fill.full_after_8", {31'd0, bus.full}, 32'd1);
    step("fill.drop_9th", 1'b0, 1'b1, 32'hDEAD_BEEF);

    for (int i = 1; i <= 8; i++) begin
      step("drain", 1'b1, 1'b0, 32'h0);
      chk("drain.order", bus.data_out, 32'(i) * 32'h1111_1111);
    end
    step("drain.read_empty", 1'b1, 1'b0, 32'h0);
    chk("drain.hold_last", bus.data_out, 32'h8888_8888);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++)
        step("wrap.push", 1'b0, 1'b1, 32'hC000_0000 + 32'(r * 16 + k));
      for (int k = 0; k < 5; k++)
        step("wrap.pop", 1'b1, 1'b0, 32'h0);
      chk("wrap.empty_round", {31'd0, bus.empty}, 32'd1);
    end

    step("sim_empty", 1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("sim_empty.dout_kept", bus.data_out, 32'hC000_0024);
    step("sim_empty.pop", 1'b1, 1'b0, 32'h0);
    chk("sim_empty.popped", bus.data_out, 32'hA5A5_A5A5);

    for (int i = 0; i < 8; i++)
      step("sim_full.fill", 1'b0, 1'b1, 32'h5000_0000 + 32'(i));
    step("sim_full", 1'b1, 1'b1, 32'hF00D_F00D);
    chk("sim_full.oldest_out", bus.data_out, 32'h5000_0000);
    chk("sim_full.still_full", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 8; i++)
      step("sim_full.drain", 1'b1, 1'b0, 32'h0);
    chk("sim_full.new_last", bus.data_out, 32'hF00D_F00D);

    for (int i = 0; i < 4; i++)
      step("areset.push", 1'b0, 1'b1, 32'h7700_0000 + 32'(i));
    step("areset.pop", 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    sb_q.delete();
    exp_dout = '0;
    chk_state("areset.immediate");
    @(negedge clk);
    rst = 1'b1;
    #1;
    step("areset.idle_after", 1'b0, 1'b0, 32'h0);
    step("areset.read_empty", 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
